// File: rtl/vga_stream_monitor.sv
// vga_stream_monitor: receiver-side checker for the TinyTapeout VGA PMOD bus
// (bit order R1 G1 B1 VS R0 G0 B0 HS). It recovers line and frame timing from
// HS/VS, measures totals and sync widths, tracks lock, and samples the colour
// at a programmable probe coordinate.
//
// Optional build macro: VGA_MONITOR_CRC_EN adds a per-frame CRC-16-CCITT over
// the colour bits; without it frame_crc is tied to zero.
//
// Lock state table:
//   state     | meaning
//   ST_IDLE   | no reference; the first frame_done after reset/clear is ignored
//   ST_CAND   | reference (h_total, v_total) stored, waiting for a matching frame
//   ST_LOCKED | consecutive frames match the reference; locked = 1
module vga_stream_monitor #(
    parameter int H_W    = 11,
    parameter int V_W    = 10,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           clear,
    input  logic [7:0]     vga_in,
    input  logic [H_W-1:0] probe_x,
    input  logic [V_W-1:0] probe_y,
    output logic [H_W-1:0] h_total,
    output logic [H_W-1:0] h_sync_w,
    output logic [V_W-1:0] v_total,
    output logic [V_W-1:0] v_sync_w,
    output logic [5:0]     probe_rgb,
    output logic           locked,
    output logic           frame_done,
    output logic [7:0]     frame_count,
    output logic           err_sticky,
    output logic [15:0]    frame_crc
);

    typedef enum logic [1:0] {ST_IDLE, ST_CAND, ST_LOCKED} state_t;

    // Reset the input stage to inactive sync levels so the first asserted
    // pixel after reset is seen as an edge.
    localparam logic [7:0] BUS_IDLE  = {3'b000, ~VS_POL, 3'b000, ~HS_POL};
    localparam logic [1:0] SYNC_IDLE = {~VS_POL, ~HS_POL};

    logic [7:0]     vga_r;
    logic [1:0]     sync_p;
    logic           hs_act, vs_act, hs_prev, vs_prev;
    logic           hs_rise, hs_fall, vs_rise;
    logic [5:0]     colour;

    logic [H_W-1:0] h_cnt, h_cnt_nxt, h_inc, hs_cnt;
    logic           h_sat, hs_cnt_sat, h_seen;
    logic [V_W-1:0] v_cnt, v_cnt_nxt, v_inc, vs_hcnt, vs_hcnt_nxt, vs_hcnt_inc;

    state_t         state;
    logic           first_done;
    logic [H_W-1:0] ref_h;
    logic [V_W-1:0] ref_v;
    logic           ref_match;

    assign hs_act  = (vga_r[0] == HS_POL);
    assign vs_act  = (vga_r[4] == VS_POL);
    assign hs_prev = (sync_p[0] == HS_POL);
    assign vs_prev = (sync_p[1] == VS_POL);
    assign hs_rise = ena && hs_act && !hs_prev;
    assign hs_fall = ena && !hs_act && hs_prev;
    assign vs_rise = ena && vs_act && !vs_prev;
    assign colour  = {vga_r[7], vga_r[3], vga_r[6], vga_r[2], vga_r[5], vga_r[1]};

    assign h_sat       = (h_cnt == '1);
    assign hs_cnt_sat  = (hs_cnt == '1);
    assign h_inc       = h_sat ? h_cnt : h_cnt + H_W'(1);
    assign v_inc       = (v_cnt == '1) ? v_cnt : v_cnt + V_W'(1);
    assign vs_hcnt_inc = (vs_hcnt == '1) ? vs_hcnt : vs_hcnt + V_W'(1);
    assign h_cnt_nxt   = hs_rise ? '0 : h_inc;
    assign ref_match   = (h_total == ref_h) && (v_total == ref_v);

    // Next vertical counts: a VS edge restarts the frame, then a coincident
    // HS edge counts the first line, so a frame starts at v_cnt = 1.
    always_comb begin
        v_cnt_nxt   = v_cnt;
        vs_hcnt_nxt = vs_hcnt;
        if (vs_rise) begin
            v_cnt_nxt   = '0;
            vs_hcnt_nxt = '0;
        end
        if (hs_rise) begin
            v_cnt_nxt = vs_rise ? V_W'(1) : v_inc;
            if (vs_act) begin
                vs_hcnt_nxt = vs_rise ? V_W'(1) : vs_hcnt_inc;
            end
        end
    end

    // Input stage: one register on the bus plus the previous sync levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r  <= BUS_IDLE;
            sync_p <= SYNC_IDLE;
        end else if (ena) begin
            vga_r  <= vga_in;
            sync_p <= {vga_r[4], vga_r[0]};
        end
    end

    // Line/frame measurement, frame_done pulse and probe capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt      <= '0;
            hs_cnt     <= '0;
            h_seen     <= 1'b0;
            h_total    <= '0;
            h_sync_w   <= '0;
            v_cnt      <= '0;
            vs_hcnt    <= '0;
            v_total    <= '0;
            v_sync_w   <= '0;
            frame_done <= 1'b0;
            probe_rgb  <= '0;
        end else if (ena) begin
            h_cnt <= h_cnt_nxt;
            if (hs_rise) begin
                h_seen <= 1'b1;
                if (h_seen) begin
                    h_total <= h_inc;
                end
            end else if (h_sat) begin
                // A saturated line is not a measurement; forget the edge.
                h_seen <= 1'b0;
            end
            if (hs_rise) begin
                hs_cnt <= H_W'(1);
            end else if (hs_act && !hs_cnt_sat) begin
                hs_cnt <= hs_cnt + H_W'(1);
            end
            if (hs_fall) begin
                h_sync_w <= hs_cnt;
            end
            v_cnt   <= v_cnt_nxt;
            vs_hcnt <= vs_hcnt_nxt;
            if (vs_rise) begin
                v_total  <= v_cnt;
                v_sync_w <= vs_hcnt;
            end
            frame_done <= vs_rise;
            if (h_cnt_nxt == probe_x && v_cnt_nxt == probe_y) begin
                probe_rgb <= colour;
            end
        end
    end

    // Lock tracking, error flag and frame counter; clear wins over all events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            locked      <= 1'b0;
            err_sticky  <= 1'b0;
            frame_count <= '0;
            first_done  <= 1'b0;
            ref_h       <= '0;
            ref_v       <= '0;
        end else if (clear) begin
            state       <= ST_IDLE;
            locked      <= 1'b0;
            err_sticky  <= 1'b0;
            frame_count <= '0;
            first_done  <= 1'b0;
            ref_h       <= '0;
            ref_v       <= '0;
        end else if (ena) begin
            if (vs_rise) begin
                frame_count <= frame_count + 8'd1;
            end
            if (h_sat) begin
                state  <= ST_IDLE;
                locked <= 1'b0;
            end else if (state == ST_LOCKED && hs_rise && h_seen && h_inc != ref_h) begin
                // The frame holding a bad line is not trusted as a reference.
                state      <= ST_CAND;
                locked     <= 1'b0;
                err_sticky <= 1'b1;
                ref_h      <= '0;
                ref_v      <= '0;
            end else if (frame_done) begin
                case (state)
                    ST_IDLE: begin
                        if (!first_done) begin
                            first_done <= 1'b1;
                        end else if (v_total != '0 && h_total != '0) begin
                            ref_h <= h_total;
                            ref_v <= v_total;
                            state <= ST_CAND;
                        end
                    end
                    ST_CAND: begin
                        if (ref_match) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end else begin
                            ref_h <= h_total;
                            ref_v <= v_total;
                        end
                    end
                    ST_LOCKED: begin
                        if (!ref_match) begin
                            state      <= ST_CAND;
                            locked     <= 1'b0;
                            err_sticky <= 1'b1;
                            ref_h      <= h_total;
                            ref_v      <= v_total;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef VGA_MONITOR_CRC_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) begin
                r = r ^ 16'h1021;
            end
        end
        return r;
    endfunction

    // Frame CRC: the VS-edge pixel opens a new frame with a fresh seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc       <= 16'hFFFF;
            frame_crc <= '0;
        end else if (ena) begin
            if (vs_rise) begin
                frame_crc <= crc;
                crc       <= crc_step(16'hFFFF, {2'b00, colour});
            end else begin
                crc <= crc_step(crc, {2'b00, colour});
            end
        end
    end
`else
    assign frame_crc = '0;
`endif

endmodule

// File: doc/vga_stream_monitor.md
Name: vga_stream_monitor

Overview:
- Receiver-side checker for the TinyTapeout VGA PMOD stream (uo_out bit order: R1 G1 B1 VS R0 G0 B0 HS) produced by the colour-bar generator.
- Recovers timing from HS/VS, measures line length, sync widths and lines per frame, declares lock and flags timing errors.
- Samples the pixel colour at a programmable coordinate.
- Used in simulation benches and as an on-chip self-test companion; one pixel per clk.

Parameters:
- H_W, 11, width of horizontal counters and measurements.
- V_W, 10, width of vertical counters and measurements.
- HS_POL, 0, active level of HS (0 = active-low).
- VS_POL, 0, active level of VS (0 = active-low).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  monitor enable; when low all counters and state hold.
- clear  in  1  synchronous; clears err_sticky, frame_count and lock state.
- vga_in  in  8  PMOD-ordered VGA bus.
- probe_x  in  H_W  probe column (clocks after HS assertion edge).
- probe_y  in  V_W  probe line (HS edges after VS assertion edge).
- h_total  out  H_W  last measured line length in clocks.
- h_sync_w  out  H_W  last measured HS pulse width.
- v_total  out  V_W  last measured lines per frame.
- v_sync_w  out  V_W  HS edges counted while VS asserted, last frame.
- probe_rgb  out  6  {R1,R0,G1,G0,B1,B0} captured at the probe point.
- locked  out  1  timing stable.
- frame_done  out  1  one-cycle pulse at each VS assertion edge.
- frame_count  out  8  frames seen, wraps 255->0.
- err_sticky  out  1  timing changed while locked.
- frame_crc  out  16  see Optional Feature.

Behaviour:
- Reset: all outputs 0; internal counters 0; lock state IDLE.
- Input stage: vga_in registered once. Edge detection uses registered value vs previous registered value. Latency: edge seen on vga_in at cycle n is acted on at cycle n+2.
- Horizontal:
  - h_cnt resets to 0 on an HS assertion edge, else increments.
  - On each assertion edge with a prior edge seen: h_total <= h_cnt+1.
  - hs_cnt counts asserted cycles; on HS deassertion edge: h_sync_w <= hs_cnt.
  - h_cnt saturates at all-ones (no wrap). Saturation forces locked=0 and state IDLE.
- Vertical:
  - v_cnt resets to 0 on a VS assertion edge, increments on each HS assertion edge, saturates.
  - On VS assertion edge: v_total <= v_cnt, v_sync_w <= latched count; frame_done=1; frame_count++.
  - HS and VS edges in the same cycle: VS handling first, then the HS increment, so v_cnt=1.
- Probe: when h_cnt==probe_x and v_cnt==probe_y, probe_rgb <= registered colour bits. Held until the next match. Only one capture per frame is possible.
- Lock FSM, evaluated at each frame_done:
  - IDLE -> CAND when v_total!=0 and h_total!=0; store reference (h_total, v_total).
  - CAND -> LOCKED if the new measurements equal the reference; else stay CAND with a new reference.
  - LOCKED -> CAND on mismatch, setting err_sticky.
  - Also in LOCKED: any line whose h_total differs from the reference sets err_sticky and drops to CAND immediately.
  - locked=1 only in LOCKED.
- The first frame after reset or clear is partial and is never used as a reference; IDLE ignores the first frame_done.
- clear takes priority over simultaneous events. Reset mid-frame restarts the partial-frame rule.
- ena=0: registers hold, no edges are detected, and the input stage is also frozen.

Optional Feature:
- Macro: VGA_MONITOR_CRC_EN.
- Defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection) over the 6 registered colour bits, zero-extended to 8, of every clock in the frame.
  - At the VS assertion edge, frame_crc <= final CRC and the CRC reinitialises.
  - frame_crc is valid with frame_done.
- Not defined: frame_crc constant 0; no CRC logic.

Test Plan:
- Synthetic mode, HS_POL=VS_POL=0: line 20 clocks, HS low 3 clocks, 10 lines per frame, VS low 2 lines, 3 frames. Required: h_total=20, h_sync_w=3, v_total=10, v_sync_w=2, locked=1 after the third frame_done, frame_count=3.
- 640x480 timing, 800x525, HS 96, VS 2, pixel colour = bar index. Required: h_total=800, v_total=525. With probe_x=200, probe_y=100, probe_rgb equals the bar colour driven at that clock.
- While locked, one line shortened to 19 clocks. Required: err_sticky=1, locked=0 next cycle, relock after 2 good frames. Then clear=1 -> err_sticky=0, frame_count=0.
- HS held inactive 2048+ clocks. Required: h_cnt saturates at 2047, locked=0, no wrap artefacts.
- rst_n low mid-frame, then released. Required: all outputs 0 during reset; first frame_done does not advance lock; locked after frames 2 and 3 match.
- VGA_MONITOR_CRC_EN defined, 3 identical frames. Required: frame_crc identical at each frame_done and equal to the bench model's value. Undefined: frame_crc=0 throughout.
